// File: rtl/kul_mult_pipe.sv
// Pipelined unsigned recursive multiplier built from 2x2 digit products,
// with per-transaction exact / Kulkarni-approximate mode and valid/ready flow control.
module kul_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Y,
  output logic                 out_err,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     approx_cnt
);

  localparam int LAT = $clog2(WIDTH);
  localparam int N   = WIDTH / 2;
  localparam int NP  = N * N;
  localparam int PW  = 2 * WIDTH;

  logic           en;
  logic           take;
  logic           hit_d;
  logic [PW-1:0]  prod_d [LAT][NP];
  logic [PW-1:0]  prod_q [LAT][NP];
  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] hit_q;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign take      = in_valid && en;
  assign out_valid = vld_q[LAT-1];
  assign out_err   = hit_q[LAT-1];
  assign Y         = prod_q[LAT-1][0];

  // Stage g holds products of (2<<g)-bit sub-operands, entry index = a_idx*ns + b_idx.
  always_comb begin
    logic [1:0] ad;
    logic [1:0] bd;
    logic [3:0] dp;
    int         ns;
    int         nsp;
    int         k;
    ad    = '0;
    bd    = '0;
    dp    = '0;
    ns    = 0;
    nsp   = 0;
    k     = 0;
    hit_d = 1'b0;
    for (int g = 0; g < LAT; g++) begin
      for (int e = 0; e < NP; e++) begin
        prod_d[g][e] = '0;
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ad = a[2*i +: 2];
        bd = b[2*j +: 2];
        if (mode) begin
          dp = {1'b0, ad[1] & bd[1], (ad[1] & bd[0]) | (ad[0] & bd[1]), ad[0] & bd[0]};
        end else begin
          dp = {2'b00, ad} * {2'b00, bd};
        end
        hit_d = hit_d | (mode & (&ad) & (&bd));
        prod_d[0][i*N + j] = PW'(dp);
      end
    end
    for (int g = 1; g < LAT; g++) begin
      ns  = WIDTH >> (g + 1);
      nsp = 2 * ns;
      k   = 1 << g;
      for (int i = 0; i < ns; i++) begin
        for (int j = 0; j < ns; j++) begin
          prod_d[g][i*ns + j] = prod_q[g-1][(2*i)*nsp + 2*j]
                              + (prod_q[g-1][(2*i+1)*nsp + 2*j] << k)
                              + (prod_q[g-1][(2*i)*nsp + 2*j + 1] << k)
                              + (prod_q[g-1][(2*i+1)*nsp + 2*j + 1] << (2*k));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      hit_q <= '0;
      for (int g = 0; g < LAT; g++) begin
        for (int e = 0; e < NP; e++) begin
          prod_q[g][e] <= '0;
        end
      end
    end else if (en) begin
      vld_q[0] <= take;
      hit_q[0] <= take & hit_d;
      for (int g = 1; g < LAT; g++) begin
        vld_q[g] <= vld_q[g-1];
        hit_q[g] <= hit_q[g-1];
      end
      for (int g = 0; g < LAT; g++) begin
        for (int e = 0; e < NP; e++) begin
          prod_q[g][e] <= prod_d[g][e];
        end
      end
    end
  end

  // Clear has priority over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      approx_cnt <= '0;
    end else if (clr_cnt) begin
      approx_cnt <= '0;
    end else if (out_valid && out_ready && out_err && (approx_cnt != {CNT_W{1'b1}})) begin
      approx_cnt <= approx_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_kul_mult_pipe.sv
// Scoreboard bench for kul_mult_pipe: an 8-bit and a 4-bit (CNT_W=2) instance driven in lockstep.
module tb_kul_mult_pipe;

  typedef struct packed {
    logic [15:0] y;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic        mode = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_cnt = 1'b0;

  logic        in_ready8, out_valid8, out_err8;
  logic [15:0] Y8;
  logic [15:0] approx_cnt8;
  logic        in_ready4, out_valid4, out_err4;
  logic [7:0]  Y4;
  logic [1:0]  approx_cnt4;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t        q8[$];
  exp_t        q4[$];
  logic [15:0] ecnt8 = '0;
  logic [1:0]  ecnt4 = '0;
  logic        stall8 = 1'b0, stall4 = 1'b0;
  logic [15:0] sy8 = '0;
  logic [7:0]  sy4 = '0;
  logic        se8 = 1'b0, se4 = 1'b0;

  always #5 clk = ~clk;

  kul_mult_pipe #(.WIDTH(8), .CNT_W(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a_in), .b(b_in), .mode(mode), .out_valid(out_valid8), .out_ready(out_ready),
    .Y(Y8), .out_err(out_err8), .clr_cnt(clr_cnt), .approx_cnt(approx_cnt8)
  );

  kul_mult_pipe #(.WIDTH(4), .CNT_W(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a_in[3:0]), .b(b_in[3:0]), .mode(mode), .out_valid(out_valid4), .out_ready(out_ready),
    .Y(Y4), .out_err(out_err4), .clr_cnt(clr_cnt), .approx_cnt(approx_cnt4)
  );

  // Reference: sum of digit products, approximate digit product maps 3x3 to 7.
  function automatic logic [15:0] ref_mul(input int w, input logic [7:0] av, input logic [7:0] bv,
                                          input logic m);
    logic [15:0] acc;
    logic [1:0]  ad, bd;
    logic [3:0]  p;
    acc = '0;
    for (int i = 0; i < w/2; i++) begin
      for (int j = 0; j < w/2; j++) begin
        ad = av[2*i +: 2];
        bd = bv[2*j +: 2];
        p  = (m && ad == 2'd3 && bd == 2'd3) ? 4'd7 : ({2'b00, ad} * {2'b00, bd});
        acc = acc + (16'(p) << (2*(i+j)));
      end
    end
    return acc;
  endfunction

  function automatic logic ref_hit(input int w, input logic [7:0] av, input logic [7:0] bv,
                                   input logic m);
    logic h;
    h = 1'b0;
    for (int i = 0; i < w/2; i++) begin
      for (int j = 0; j < w/2; j++) begin
        if (av[2*i +: 2] == 2'd3 && bv[2*j +: 2] == 2'd3) h = 1'b1;
      end
    end
    return h & m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic step(input logic iv, input logic [7:0] av, input logic [7:0] bv, input logic m,
                      input logic ordy, input logic clr = 1'b0, input logic kn = 1'b0,
                      input logic [15:0] ky = '0, input logic ke = 1'b0);
    exp_t e;
    in_valid = iv; a_in = av; b_in = bv; mode = m; out_ready = ordy; clr_cnt = clr;
    #1;
    check("cnt8", approx_cnt8, ecnt8);
    check("cnt4", approx_cnt4, ecnt4);
    check("rdy8", in_ready8, !out_valid8 || ordy);
    check("rdy4", in_ready4, !out_valid4 || ordy);
    if (stall8) begin
      check("stall_v8", out_valid8, 1);
      check("stall_y8", Y8, sy8);
      check("stall_e8", out_err8, se8);
    end
    if (stall4) begin
      check("stall_v4", out_valid4, 1);
      check("stall_y4", Y4, sy4);
      check("stall_e4", out_err4, se4);
    end
    if (out_valid8 && ordy) begin
      if (q8.size() == 0) check("spurious8", out_valid8, 0);
      else begin
        e = q8.pop_front();
        check("y8", Y8, e.y);
        check("err8", out_err8, e.err);
        if (e.err && ecnt8 != 16'hFFFF) ecnt8 = ecnt8 + 1'b1;
      end
    end
    if (out_valid4 && ordy) begin
      if (q4.size() == 0) check("spurious4", out_valid4, 0);
      else begin
        e = q4.pop_front();
        check("y4", Y4, e.y);
        check("err4", out_err4, e.err);
        if (e.err && ecnt4 != 2'd3) ecnt4 = ecnt4 + 1'b1;
      end
    end
    if (clr) begin
      ecnt8 = '0;
      ecnt4 = '0;
    end
    if (iv && in_ready8) begin
      e.y   = kn ? ky : ref_mul(8, av, bv, m);
      e.err = kn ? ke : ref_hit(8, av, bv, m);
      q8.push_back(e);
    end
    if (iv && in_ready4) begin
      e.y   = ref_mul(4, av, bv, m);
      e.err = ref_hit(4, av, bv, m);
      q4.push_back(e);
    end
    stall8 = out_valid8 && !ordy; sy8 = Y8; se8 = out_err8;
    stall4 = out_valid4 && !ordy; sy4 = Y4; se4 = out_err4;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q8.size() != 0 || q4.size() != 0); i++) step(0, 0, 0, 0, 1);
    check("drain8", q8.size(), 0);
    check("drain4", q4.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_v8", out_valid8, 0);
    check("rst_y8", Y8, 0);
    check("rst_e8", out_err8, 0);
    check("rst_cnt8", approx_cnt8, 0);
    check("rst_rdy8", in_ready8, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Latency and directed products
    step(1, 8'd255, 8'd255, 1, 1, 0, 1, 16'd50575, 1);
    check("lat8_e1", out_valid8, 0);
    check("lat4_e1", out_valid4, 0);
    step(0, 0, 0, 0, 1);
    check("lat8_e2", out_valid8, 0);
    check("lat4_e2", out_valid4, 1);
    step(0, 0, 0, 0, 1);
    check("lat8_e3", out_valid8, 1);
    step(1, 8'd255, 8'd255, 0, 1, 0, 1, 16'd65025, 0);
    step(1, 8'd15,  8'd15,  1, 1, 0, 1, 16'd175,   1);
    step(1, 8'd6,   8'd7,   1, 1, 0, 1, 16'd42,    0);
    step(1, 8'd255, 8'd85,  1, 1, 0, 1, 16'd21675, 0);
    drain();

    // Random stream with alternating mode and random backpressure
    for (int k = 0; k < 20; k++) begin
      step(1, 8'($urandom), 8'($urandom), k[0], 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 1'($urandom_range(0, 1)));
    drain();

    // Reset with operations in flight
    step(1, 8'd200, 8'd255, 1, 0);
    step(1, 8'd255, 8'd15,  1, 0);
    step(1, 8'd99,  8'd51,  0, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_v8", out_valid8, 0);
    check("mid_rst_v4", out_valid4, 0);
    check("mid_rst_rdy8", in_ready8, 1);
    check("mid_rst_cnt8", approx_cnt8, 0);
    q8.delete(); q4.delete();
    ecnt8 = '0; ecnt4 = '0;
    stall8 = 1'b0; stall4 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 1);

    // Exhaustive 4-bit sweep, both modes
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) step(1, 8'(x), 8'(y), m[0], 1);
      end
    end
    drain();

    // Counter saturation at CNT_W=2 and clear against a coincident increment
    step(0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 5; k++) step(1, 8'd15, 8'd15, 1, 1);
    drain();
    check("sat4", approx_cnt4, 3);
    step(1, 8'd15, 8'd15, 1, 1);
    step(0, 0, 0, 0, 0);
    check("pre_clr_v4", out_valid4, 1);
    check("pre_clr_e4", out_err4, 1);
    step(0, 0, 0, 0, 1, 1);
    check("clr4", approx_cnt4, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
